// File: rtl/game_pkg.sv
// Shared encodings, coordinate widths and start positions for the game control path.
package game_pkg;

   localparam int unsigned X_W  = 8;
   localparam int unsigned Y_W  = 7;
   localparam int unsigned CD_W = 8;

   typedef enum logic [1:0] {
      StTitle = 2'd0,
      StPlay  = 2'd1,
      StPause = 2'd2,
      StOver  = 2'd3
   } game_state_e;

   typedef enum logic [1:0] {
      DirUp    = 2'd0,
      DirRight = 2'd1,
      DirDown  = 2'd2,
      DirLeft  = 2'd3
   } dir_e;

   localparam logic [X_W-1:0] P1_X0   = 8'd20;
   localparam logic [Y_W-1:0] P1_Y0   = 7'd60;
   localparam dir_e           P1_DIR0 = DirRight;
   localparam logic [X_W-1:0] P2_X0   = 8'd140;
   localparam logic [Y_W-1:0] P2_Y0   = 7'd60;
   localparam dir_e           P2_DIR0 = DirLeft;

   // Move a coordinate by a signed delta, saturating at 0 and at limit.
   function automatic logic [8:0] step_clamp(input logic [8:0]        pos,
                                             input logic signed [8:0] delta,
                                             input logic [8:0]        limit);
      logic signed [8:0] sum;
      sum = $signed(pos) + delta;
      if (sum < 0) begin
         return '0;
      end
      if (sum > $signed(limit)) begin
         return limit;
      end
      return $unsigned(sum);
   endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// Key levels from the PS/2 decoder in, game state and player outputs out.
interface player_ctrl_if;
   import game_pkg::*;

   logic key_w, key_a, key_s, key_d;
   logic key_i, key_j, key_k, key_l;
   logic key_space, key_enter, key_esc;
   logic game_over;

   game_state_e     state;
   logic            frame_tick;
   logic [X_W-1:0]  p1_x, p2_x;
   logic [Y_W-1:0]  p1_y, p2_y;
   dir_e            p1_dir, p2_dir;
   logic            p1_fire, p2_fire;
   logic [CD_W-1:0] p1_cooldown, p2_cooldown;

   modport master (
      output key_w, key_a, key_s, key_d,
      output key_i, key_j, key_k, key_l,
      output key_space, key_enter, key_esc,
      output game_over,
      input  state, frame_tick,
      input  p1_x, p1_y, p1_dir, p1_fire, p1_cooldown,
      input  p2_x, p2_y, p2_dir, p2_fire, p2_cooldown
   );

   modport slave (
      input  key_w, key_a, key_s, key_d,
      input  key_i, key_j, key_k, key_l,
      input  key_space, key_enter, key_esc,
      input  game_over,
      output state, frame_tick,
      output p1_x, p1_y, p1_dir, p1_fire, p1_cooldown,
      output p2_x, p2_y, p2_dir, p2_fire, p2_cooldown
   );

endinterface

// File: rtl/player_motion.sv
// One player's position, facing and fire cooldown, advanced once per frame while enabled.
module player_motion
   import game_pkg::*;
#(
   parameter int unsigned    X_MAX   = 159,
   parameter int unsigned    Y_MAX   = 119,
   parameter int unsigned    STEP    = 1,
   parameter int unsigned    FIRE_CD = 30,
   parameter logic [X_W-1:0] X0      = '0,
   parameter logic [Y_W-1:0] Y0      = '0,
   parameter dir_e           DIR0    = DirUp
) (
   input  logic            CLOCK_50,
   input  logic            resetn,
   input  logic            up,
   input  logic            left,
   input  logic            down,
   input  logic            right,
   input  logic            fire_edge,
   input  logic            frame_tick,
   input  logic            enable,
   input  logic            load_start,
   output logic [X_W-1:0]  x,
   output logic [Y_W-1:0]  y,
   output dir_e            dir,
   output logic            fire,
   output logic [CD_W-1:0] cooldown
);

   localparam logic signed [8:0] STEP_S = 9'(STEP);

   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   dir_e              dir_q, dir_d;
   logic              fire_q, fire_d;
   logic [CD_W-1:0]   cd_q, cd_d;
   logic signed [8:0] dx, dy;
   logic              move;

   always_comb begin
      dx = '0;
      dy = '0;
      if (right && !left) begin
         dx = STEP_S;
      end else if (left && !right) begin
         dx = -STEP_S;
      end
      if (down && !up) begin
         dy = STEP_S;
      end else if (up && !down) begin
         dy = -STEP_S;
      end
   end

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      dir_d  = dir_q;
      cd_d   = cd_q;
      move   = enable && frame_tick;
      // Edges arriving during cooldown are dropped, never queued.
      fire_d = enable && fire_edge && (cd_q == '0);

      if (move) begin
         x_d = X_W'(step_clamp({1'b0, x_q}, dx, 9'(X_MAX)));
         y_d = Y_W'(step_clamp({2'b00, y_q}, dy, 9'(Y_MAX)));
         if (dx > 0) begin
            dir_d = DirRight;
         end else if (dx < 0) begin
            dir_d = DirLeft;
         end else if (dy > 0) begin
            dir_d = DirDown;
         end else if (dy < 0) begin
            dir_d = DirUp;
         end
         if (cd_q != '0) begin
            cd_d = cd_q - 1'b1;
         end
      end

      if (fire_d) begin
         cd_d = CD_W'(FIRE_CD);
      end

      if (load_start) begin
         x_d    = X0;
         y_d    = Y0;
         dir_d  = DIR0;
         cd_d   = '0;
         fire_d = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         x_q    <= X0;
         y_q    <= Y0;
         dir_q  <= DIR0;
         fire_q <= 1'b0;
         cd_q   <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         dir_q  <= dir_d;
         fire_q <= fire_d;
         cd_q   <= cd_d;
      end
   end

   assign x        = x_q;
   assign y        = y_q;
   assign dir      = dir_q;
   assign fire     = fire_q;
   assign cooldown = cd_q;

endmodule

// File: rtl/player_ctrl.sv
// Game-state FSM, frame divider and key edge detection driving two player_motion units.
module player_ctrl
   import game_pkg::*;
#(
   parameter int unsigned X_MAX     = 159,
   parameter int unsigned Y_MAX     = 119,
   parameter int unsigned FRAME_DIV = 833333,
   parameter int unsigned STEP      = 1,
   parameter int unsigned FIRE_CD   = 30
) (
   input logic          CLOCK_50,
   input logic          resetn,
   player_ctrl_if.slave bus
);

   localparam int unsigned      CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             frame_tick;
   game_state_e      state_q, state_d;
   logic             enter_prev_q, space_prev_q, esc_prev_q;
   logic             enter_edge, space_edge, esc_edge;
   logic             load_start;
   logic             play;

   logic [X_W-1:0]   p1_x, p2_x;
   logic [Y_W-1:0]   p1_y, p2_y;
   dir_e             p1_dir, p2_dir;
   logic             p1_fire, p2_fire;
   logic [CD_W-1:0]  p1_cd, p2_cd;

   // Key levels are already synchronous; prev regs reset high so held keys give no edge.
   assign enter_edge = bus.key_enter & ~enter_prev_q;
   assign space_edge = bus.key_space & ~space_prev_q;
   assign esc_edge   = bus.key_esc & ~esc_prev_q;

   always_comb begin
      frame_tick  = (frame_cnt_q == CNT_LAST);
      frame_cnt_d = frame_tick ? '0 : frame_cnt_q + CNT_W'(1);
   end

   always_comb begin
      state_d    = state_q;
      load_start = 1'b0;
      unique case (state_q)
         StTitle: begin
            if (enter_edge || space_edge) begin
               state_d    = StPlay;
               load_start = 1'b1;
            end
         end
         StPlay: begin
            if (bus.game_over) begin
               state_d = StOver;
            end else if (esc_edge) begin
               state_d = StPause;
            end
         end
         StPause: begin
            if (esc_edge) begin
               state_d = StTitle;
            end else if (enter_edge) begin
               state_d = StPlay;
            end
         end
         StOver: begin
            if (enter_edge) begin
               state_d = StTitle;
            end
         end
         default: state_d = StTitle;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         frame_cnt_q  <= '0;
         state_q      <= StTitle;
         enter_prev_q <= 1'b1;
         space_prev_q <= 1'b1;
         esc_prev_q   <= 1'b1;
      end else begin
         frame_cnt_q  <= frame_cnt_d;
         state_q      <= state_d;
         enter_prev_q <= bus.key_enter;
         space_prev_q <= bus.key_space;
         esc_prev_q   <= bus.key_esc;
      end
   end

   // Resume/start transitions leave PLAY inactive this cycle, so their Enter edge cannot fire.
   assign play = (state_q == StPlay);

   player_motion #(
      .X_MAX   (X_MAX),
      .Y_MAX   (Y_MAX),
      .STEP    (STEP),
      .FIRE_CD (FIRE_CD),
      .X0      (P1_X0),
      .Y0      (P1_Y0),
      .DIR0    (P1_DIR0)
   ) u_p1 (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .up         (bus.key_w),
      .left       (bus.key_a),
      .down       (bus.key_s),
      .right      (bus.key_d),
      .fire_edge  (space_edge),
      .frame_tick (frame_tick),
      .enable     (play),
      .load_start (load_start),
      .x          (p1_x),
      .y          (p1_y),
      .dir        (p1_dir),
      .fire       (p1_fire),
      .cooldown   (p1_cd)
   );

   player_motion #(
      .X_MAX   (X_MAX),
      .Y_MAX   (Y_MAX),
      .STEP    (STEP),
      .FIRE_CD (FIRE_CD),
      .X0      (P2_X0),
      .Y0      (P2_Y0),
      .DIR0    (P2_DIR0)
   ) u_p2 (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .up         (bus.key_i),
      .left       (bus.key_j),
      .down       (bus.key_k),
      .right      (bus.key_l),
      .fire_edge  (enter_edge),
      .frame_tick (frame_tick),
      .enable     (play),
      .load_start (load_start),
      .x          (p2_x),
      .y          (p2_y),
      .dir        (p2_dir),
      .fire       (p2_fire),
      .cooldown   (p2_cd)
   );

   assign bus.state       = state_q;
   assign bus.frame_tick  = frame_tick;
   assign bus.p1_x        = p1_x;
   assign bus.p1_y        = p1_y;
   assign bus.p1_dir      = p1_dir;
   assign bus.p1_fire     = p1_fire;
   assign bus.p1_cooldown = p1_cd;
   assign bus.p2_x        = p2_x;
   assign bus.p2_y        = p2_y;
   assign bus.p2_dir      = p2_dir;
   assign bus.p2_fire     = p2_fire;
   assign bus.p2_cooldown = p2_cd;

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: FSM vector table, hand-written corner sequences, random run vs model.
module tb_player_ctrl;
   import game_pkg::*;

   localparam int FD   = 4;
   localparam int XMAX = 159;
   localparam int YMAX = 119;
   localparam int CD   = 30;

   logic CLOCK_50 = 1'b0;
   logic resetn   = 1'b0;

   player_ctrl_if bus ();

   player_ctrl #(
      .FRAME_DIV (FD)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int checks   = 0;
   int failures = 0;

   // Reference model: plain game rules on integers.
   int m_state, m_cnt;
   int m_x[2], m_y[2], m_dir[2], m_cd[2];
   int m_fire[2];
   bit pv_enter, pv_space, pv_esc;

   typedef struct {
      int enter, space, esc, go, st, f1, f2;
   } vec_t;
   vec_t tbl [24];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   function automatic void model_reset();
      m_state  = 0;
      m_cnt    = 0;
      m_x      = '{20, 140};
      m_y      = '{60, 60};
      m_dir    = '{1, 3};
      m_cd     = '{0, 0};
      m_fire   = '{0, 0};
      pv_enter = 1'b1;
      pv_space = 1'b1;
      pv_esc   = 1'b1;
   endfunction

   function automatic void model_step();
      bit e_en, e_sp, e_esc, tick;
      int dx[2], dy[2], fe[2];
      e_en  = bus.key_enter && !pv_enter;
      e_sp  = bus.key_space && !pv_space;
      e_esc = bus.key_esc && !pv_esc;
      tick  = (m_cnt == FD - 1);
      dx[0] = int'(bus.key_d) - int'(bus.key_a);
      dy[0] = int'(bus.key_s) - int'(bus.key_w);
      dx[1] = int'(bus.key_l) - int'(bus.key_j);
      dy[1] = int'(bus.key_k) - int'(bus.key_i);
      fe[0] = int'(e_sp);
      fe[1] = int'(e_en);
      m_fire = '{0, 0};
      case (m_state)
         0: if (e_en || e_sp) begin
            m_state = 1;
            m_x = '{20, 140}; m_y = '{60, 60}; m_dir = '{1, 3}; m_cd = '{0, 0};
         end
         1: begin
            for (int p = 0; p < 2; p++) begin
               if (fe[p] != 0 && m_cd[p] == 0) m_fire[p] = 1;
               if (tick) begin
                  m_x[p] = clampi(m_x[p] + dx[p], XMAX);
                  m_y[p] = clampi(m_y[p] + dy[p], YMAX);
                  if (dx[p] != 0) m_dir[p] = (dx[p] > 0) ? 1 : 3;
                  else if (dy[p] != 0) m_dir[p] = (dy[p] > 0) ? 2 : 0;
                  if (m_cd[p] > 0) m_cd[p] = m_cd[p] - 1;
               end
               if (m_fire[p] != 0) m_cd[p] = CD;
            end
            if (bus.game_over) m_state = 3;
            else if (e_esc) m_state = 2;
         end
         2: if (e_esc) m_state = 0; else if (e_en) m_state = 1;
         default: if (e_en) m_state = 0;
      endcase
      m_cnt    = (m_cnt + 1) % FD;
      pv_enter = bus.key_enter;
      pv_space = bus.key_space;
      pv_esc   = bus.key_esc;
   endfunction

   task automatic model_check();
      chk("state", int'(bus.state), m_state);
      chk("frame_tick", int'(bus.frame_tick), int'(m_cnt == FD - 1));
      chk("p1_x", int'(bus.p1_x), m_x[0]);
      chk("p1_y", int'(bus.p1_y), m_y[0]);
      chk("p1_dir", int'(bus.p1_dir), m_dir[0]);
      chk("p1_fire", int'(bus.p1_fire), m_fire[0]);
      chk("p1_cooldown", int'(bus.p1_cooldown), m_cd[0]);
      chk("p2_x", int'(bus.p2_x), m_x[1]);
      chk("p2_y", int'(bus.p2_y), m_y[1]);
      chk("p2_dir", int'(bus.p2_dir), m_dir[1]);
      chk("p2_fire", int'(bus.p2_fire), m_fire[1]);
      chk("p2_cooldown", int'(bus.p2_cooldown), m_cd[1]);
   endtask

   function automatic void keys_clear();
      bus.key_w = 1'b0; bus.key_a = 1'b0; bus.key_s = 1'b0; bus.key_d = 1'b0;
      bus.key_i = 1'b0; bus.key_j = 1'b0; bus.key_k = 1'b0; bus.key_l = 1'b0;
      bus.key_space = 1'b0; bus.key_enter = 1'b0; bus.key_esc = 1'b0;
      bus.game_over = 1'b0;
   endfunction

   // Called on a falling edge; leaves the bench on a falling edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         model_step();
         @(posedge CLOCK_50);
         @(negedge CLOCK_50);
         model_check();
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_reset();
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      resetn = 1'b1;
      model_check();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int pulses;
      tbl = '{
         '{0,0,0,0, 0, 0,0}, '{1,0,0,0, 1, 0,0}, '{1,0,0,0, 1, 0,0}, '{0,0,0,0, 1, 0,0},
         '{1,0,0,0, 1, 0,1}, '{0,1,0,0, 1, 1,0}, '{0,0,1,0, 2, 0,0}, '{0,0,0,0, 2, 0,0},
         '{1,0,1,0, 0, 0,0}, '{0,0,0,0, 0, 0,0}, '{0,0,0,1, 0, 0,0}, '{0,1,0,0, 1, 0,0},
         '{0,0,1,1, 3, 0,0}, '{0,0,0,0, 3, 0,0}, '{1,0,0,0, 0, 0,0}, '{0,0,0,1, 0, 0,0},
         '{1,0,0,0, 1, 0,0}, '{0,0,1,0, 2, 0,0}, '{0,0,0,0, 2, 0,0}, '{1,0,0,0, 1, 0,0},
         '{0,0,0,0, 1, 0,0}, '{1,0,0,0, 1, 0,1}, '{0,0,0,0, 1, 0,0}, '{1,0,0,0, 1, 0,0}
      };
      keys_clear();
      model_reset();
      @(negedge CLOCK_50);
      do_reset();
      chk("reset_state", int'(bus.state), 0);
      chk("reset_p1_x", int'(bus.p1_x), 20);
      chk("reset_p2_dir", int'(bus.p2_dir), 3);

      // FSM transitions and fire pulses, one row per cycle.
      for (int i = 0; i < 24; i++) begin
         bus.key_enter = (tbl[i].enter != 0);
         bus.key_space = (tbl[i].space != 0);
         bus.key_esc   = (tbl[i].esc != 0);
         bus.game_over = (tbl[i].go != 0);
         cyc(1);
         chk($sformatf("tbl%0d_state", i), int'(bus.state), tbl[i].st);
         chk($sformatf("tbl%0d_p1_fire", i), int'(bus.p1_fire), tbl[i].f1);
         chk($sformatf("tbl%0d_p2_fire", i), int'(bus.p2_fire), tbl[i].f2);
      end

      // Enter held through reset gives no edge.
      keys_clear();
      bus.key_enter = 1'b1;
      do_reset();
      cyc(3);
      chk("held_enter_title", int'(bus.state), 0);
      bus.key_enter = 1'b0;
      cyc(1);
      bus.key_enter = 1'b1;
      cyc(1);
      chk("start_state", int'(bus.state), 1);
      chk("start_p1_x", int'(bus.p1_x), 20);
      chk("start_p1_y", int'(bus.p1_y), 60);
      chk("start_p2_x", int'(bus.p2_x), 140);
      chk("start_p2_y", int'(bus.p2_y), 60);
      chk("start_no_p2_fire", int'(bus.p2_fire), 0);
      bus.key_enter = 1'b0;

      // Twelve cycles hold exactly three frame ticks.
      bus.key_d = 1'b1;
      cyc(12);
      chk("move_p1_x", int'(bus.p1_x), 23);
      chk("move_p1_dir", int'(bus.p1_dir), 1);
      bus.key_a = 1'b1;
      cyc(8);
      chk("both_lr_p1_x", int'(bus.p1_x), 23);

      // Drive into the walls.
      bus.key_a = 1'b0;
      bus.key_i = 1'b1;
      cyc(640);
      chk("wall_p1_x", int'(bus.p1_x), 159);
      chk("wall_p2_y", int'(bus.p2_y), 0);
      chk("wall_p2_x", int'(bus.p2_x), 140);
      chk("wall_p2_dir", int'(bus.p2_dir), 0);
      bus.key_d = 1'b0;
      bus.key_i = 1'b0;

      // Fire cooldown: repeated presses dropped, then allowed again after 30 frames.
      bus.key_space = 1'b1;
      cyc(1);
      chk("fire_first", int'(bus.p1_fire), 1);
      cyc(1);
      chk("fire_one_cycle", int'(bus.p1_fire), 0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         bus.key_space = (i % 2) != 0;
         cyc(1);
         pulses += int'(bus.p1_fire);
      end
      chk("fire_dropped", pulses, 0);
      bus.key_space = 1'b0;
      cyc(124);
      bus.key_space = 1'b1;
      cyc(1);
      chk("fire_after_cd", int'(bus.p1_fire), 1);
      bus.key_space = 1'b0;

      // Pause freezes positions; resume keeps them and does not fire.
      bus.key_esc = 1'b1;
      cyc(1);
      chk("pause_state", int'(bus.state), 2);
      bus.key_esc = 1'b0;
      bus.key_a   = 1'b1;
      bus.key_k   = 1'b1;
      cyc(20);
      chk("pause_p1_x", int'(bus.p1_x), 159);
      chk("pause_p2_y", int'(bus.p2_y), 0);
      bus.key_a     = 1'b0;
      bus.key_k     = 1'b0;
      bus.key_enter = 1'b1;
      cyc(1);
      chk("resume_state", int'(bus.state), 1);
      chk("resume_no_p2_fire", int'(bus.p2_fire), 0);
      chk("resume_p1_x", int'(bus.p1_x), 159);
      bus.key_enter = 1'b0;

      // game_over beats Esc; Enter returns to TITLE.
      bus.game_over = 1'b1;
      bus.key_esc   = 1'b1;
      cyc(1);
      chk("over_state", int'(bus.state), 3);
      bus.game_over = 1'b0;
      bus.key_esc   = 1'b0;
      cyc(1);
      bus.key_enter = 1'b1;
      cyc(1);
      chk("over_to_title", int'(bus.state), 0);
      bus.key_enter = 1'b0;

      // Asynchronous reset mid-frame and mid-cooldown.
      bus.key_space = 1'b1;
      cyc(1);
      bus.key_space = 1'b0;
      cyc(1);
      bus.key_space = 1'b1;
      bus.key_d     = 1'b1;
      cyc(6);
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      chk("areset_state", int'(bus.state), 0);
      chk("areset_frame_tick", int'(bus.frame_tick), 0);
      chk("areset_p1_x", int'(bus.p1_x), 20);
      chk("areset_p1_dir", int'(bus.p1_dir), 1);
      chk("areset_p1_cd", int'(bus.p1_cooldown), 0);
      chk("areset_p2_x", int'(bus.p2_x), 140);
      @(negedge CLOCK_50);
      resetn = 1'b1;
      keys_clear();
      model_check();

      // Random run against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) bus.key_w = ~bus.key_w;
         if ($urandom_range(7) == 0) bus.key_a = ~bus.key_a;
         if ($urandom_range(7) == 0) bus.key_s = ~bus.key_s;
         if ($urandom_range(7) == 0) bus.key_d = ~bus.key_d;
         if ($urandom_range(7) == 0) bus.key_i = ~bus.key_i;
         if ($urandom_range(7) == 0) bus.key_j = ~bus.key_j;
         if ($urandom_range(7) == 0) bus.key_k = ~bus.key_k;
         if ($urandom_range(7) == 0) bus.key_l = ~bus.key_l;
         if ($urandom_range(5) == 0) bus.key_enter = ~bus.key_enter;
         if ($urandom_range(5) == 0) bus.key_space = ~bus.key_space;
         if ($urandom_range(15) == 0) bus.key_esc = ~bus.key_esc;
         bus.game_over = ($urandom_range(149) == 0);
         cyc(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
